// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge detector.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int K_EDGE = 1;
    localparam int K_CTR  = 2;

    // Clamp an unsigned magnitude to the largest value representable in pix_w bits.
    function automatic logic [31:0] sat_pix(input logic [31:0] mag, input int pix_w);
        logic [31:0] max_v;
        max_v = (32'd1 << pix_w) - 32'd1;
        return (mag > max_v) ? max_v : mag;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Fixed COLS-deep delay line: dout is the word written DEPTH enabled cycles earlier.
module sobel_line_buf #(
    parameter int DEPTH = 256,
    parameter int W     = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_ptr;

    // Read-before-write at the same slot gives an exact DEPTH-step delay.
    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge i_clk) begin
        if (i_en) r_mem[r_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// Pixel-serial 3x3 Sobel edge detector: two cascaded line buffers feed a 3x3 window,
// per-channel |Gx|+|Gy| (or thresholded edge map) is registered onto a valid/ready stream.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int COLS  = 256,
    parameter int ROWS  = 256,
    parameter int PIX_W = 8,
    parameter int CH    = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [CH*PIX_W-1:0] in_pix,
    input  logic                thresh_en,
    input  logic [PIX_W-1:0]    thresh,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sof,
    output logic                out_eof,
    output logic [CH*PIX_W-1:0] out_pix,
    output logic                busy
);
    localparam int PW = CH * PIX_W;
    localparam int GW = PIX_W + 3;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int FW = $clog2(COLS + 2);

    typedef logic signed [GW-1:0] grad_t;
    localparam grad_t KE = grad_t'(K_EDGE);
    localparam grad_t KC = grad_t'(K_CTR);

    state_t        r_state;
    logic [FW-1:0] r_fill_cnt;
    logic [RW-1:0] r_ctr_r;
    logic [CW-1:0] r_ctr_c;
    logic          r_flush_done;
    logic          r_out_valid;
    logic          r_out_sof;
    logic          r_out_eof;
    logic [PW-1:0] r_out_pix;
    logic [PW-1:0] r_col_a [3];
    logic [PW-1:0] r_col_b [3];

    logic             w_can_step, w_take, w_sof_take, w_inject, w_shift, w_produce;
    logic             w_border, w_ctr_first, w_ctr_last, w_ctr_pre_last;
    logic [PW-1:0]    w_pix_in, w_lb1, w_lb2, w_res;
    logic [PW-1:0]    w_win [3][3];
    logic [PIX_W-1:0] w_res_ch [CH];

    assign w_can_step = out_ready || !r_out_valid;
    assign in_ready   = w_can_step && (r_state != FLUSH);
    assign w_take     = in_valid && in_ready;
    assign w_sof_take = w_take && in_sof;
    assign w_inject   = (r_state == FLUSH) && !r_flush_done && w_can_step;
    // Non-sof pixels seen while idle are consumed but never enter the window.
    assign w_shift    = (w_take && ((r_state != IDLE) || in_sof)) || w_inject;
    assign w_produce  = (w_take && (r_state == RUN) && !in_sof) || w_inject;
    assign w_pix_in   = (r_state == FLUSH) ? '0 : in_pix;

    assign w_ctr_first    = (r_ctr_r == '0) && (r_ctr_c == '0);
    assign w_ctr_last     = (r_ctr_r == RW'(ROWS - 1)) && (r_ctr_c == CW'(COLS - 1));
    assign w_ctr_pre_last = (r_ctr_r == RW'(ROWS - 2)) && (r_ctr_c == CW'(COLS - 2));
    assign w_border       = (r_ctr_r == '0) || (r_ctr_r == RW'(ROWS - 1)) ||
                            (r_ctr_c == '0) || (r_ctr_c == CW'(COLS - 1));

    sobel_line_buf #(.DEPTH(COLS), .W(PW)) u_lb1 (
        .i_clk(CLK), .i_rst(RST), .i_en(w_shift), .i_din(w_pix_in), .o_dout(w_lb1)
    );
    sobel_line_buf #(.DEPTH(COLS), .W(PW)) u_lb2 (
        .i_clk(CLK), .i_rst(RST), .i_en(w_shift), .i_din(w_lb1), .o_dout(w_lb2)
    );

    // The kernel sees the window as it will be after this shift, so the result
    // can be registered on the same edge that accepts the pixel.
    for (genvar i = 0; i < 3; i++) begin : g_win
        assign w_win[i][0] = r_col_a[i];
        assign w_win[i][1] = r_col_b[i];
    end
    assign w_win[0][2] = w_lb2;
    assign w_win[1][2] = w_lb1;
    assign w_win[2][2] = w_pix_in;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                r_col_a[i] <= '0;
                r_col_b[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < 3; i++) begin
                r_col_a[i] <= r_col_b[i];
                r_col_b[i] <= w_win[i][2];
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        localparam int LSB = (CH - 1 - k) * PIX_W;
        grad_t            w_p [3][3];
        grad_t            w_gx, w_gy, w_ax, w_ay;
        logic [GW-1:0]    w_mag;
        logic [PIX_W-1:0] w_sat;

        for (genvar i = 0; i < 3; i++) begin : g_r
            for (genvar j = 0; j < 3; j++) begin : g_c
                assign w_p[i][j] = grad_t'({3'b000, w_win[i][j][LSB +: PIX_W]});
            end
        end

        assign w_gx = (KE * w_p[0][2] + KC * w_p[1][2] + KE * w_p[2][2]) -
                      (KE * w_p[0][0] + KC * w_p[1][0] + KE * w_p[2][0]);
        assign w_gy = (KE * w_p[2][0] + KC * w_p[2][1] + KE * w_p[2][2]) -
                      (KE * w_p[0][0] + KC * w_p[0][1] + KE * w_p[0][2]);
        assign w_ax  = w_gx[GW-1] ? -w_gx : w_gx;
        assign w_ay  = w_gy[GW-1] ? -w_gy : w_gy;
        assign w_mag = $unsigned(w_ax) + $unsigned(w_ay);
        assign w_sat = PIX_W'(sat_pix(32'(w_mag), PIX_W));
        assign w_res_ch[k] = w_border  ? '0 :
                             thresh_en ? {PIX_W{(w_sat >= thresh)}} : w_sat;
    end

    always_comb begin
        w_res = '0;
        for (int k = 0; k < CH; k++) begin
            w_res[(CH - 1 - k) * PIX_W +: PIX_W] = w_res_ch[k];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_fill_cnt   <= '0;
            r_ctr_r      <= '0;
            r_ctr_c      <= '0;
            r_flush_done <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_out_pix    <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
                r_out_eof   <= 1'b0;
            end
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_pix   <= w_res;
                r_out_sof   <= w_ctr_first;
                r_out_eof   <= w_ctr_last;
                if (r_ctr_c == CW'(COLS - 1)) begin
                    r_ctr_c <= '0;
                    r_ctr_r <= w_ctr_last ? '0 : r_ctr_r + 1'b1;
                end else begin
                    r_ctr_c <= r_ctr_c + 1'b1;
                end
            end
            // A start-of-frame pixel always restarts the fill, abandoning any frame in progress.
            if (w_sof_take) begin
                r_state    <= FILL;
                r_fill_cnt <= FW'(1);
                r_ctr_r    <= '0;
                r_ctr_c    <= '0;
            end else begin
                case (r_state)
                    FILL: begin
                        if (w_take) begin
                            if (r_fill_cnt == FW'(COLS)) r_state <= RUN;
                            else r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (w_take && w_ctr_pre_last) begin
                            r_state      <= FLUSH;
                            r_flush_done <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (w_inject && w_ctr_last) r_flush_done <= 1'b1;
                        if (r_flush_done && r_out_valid && r_out_eof && out_ready) r_state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign out_pix   = r_out_pix;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: frame-level Sobel model, per-transfer compare, directed frames.
module tb_sobel_stream;
    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;

    logic        CLK, RST;
    logic        in_valid, in_ready, in_sof;
    logic [23:0] in_pix;
    logic        thresh_en;
    logic [7:0]  thresh;
    logic        out_valid, out_ready, out_sof, out_eof;
    logic [23:0] out_pix;
    logic        busy;

    sobel_stream #(.COLS(COLS), .ROWS(ROWS), .PIX_W(8), .CH(3)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pix(in_pix),
        .thresh_en(thresh_en), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .out_pix(out_pix), .busy(busy)
    );

    typedef struct packed {
        logic [23:0] pix;
        logic        sof;
        logic        eof;
    } exp_t;

    logic [23:0] img  [ROWS][COLS];
    logic [23:0] cap  [NPIX];
    logic [23:0] gold [NPIX];
    exp_t        exp_q [$];
    int          cap_n;
    int          n_tests;
    int          n_fail;
    bit          rand_mode;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always begin
        @(posedge CLK);
        #1;
        out_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Straight from the Sobel definition over the whole frame image.
    function automatic logic [23:0] model_pix(int r, int c, bit ten, logic [7:0] th);
        logic [23:0] res;
        res = '0;
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return res;
        for (int ch = 0; ch < 3; ch++) begin
            int v [3][3];
            int gx, gy, mag;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    v[i][j] = int'(img[r - 1 + i][c - 1 + j][8 * (2 - ch) +: 8]);
            gx  = (v[0][2] + 2 * v[1][2] + v[2][2]) - (v[0][0] + 2 * v[1][0] + v[2][0]);
            gy  = (v[2][0] + 2 * v[2][1] + v[2][2]) - (v[0][0] + 2 * v[0][1] + v[0][2]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (mag > 255) mag = 255;
            if (ten) mag = (mag >= int'(th)) ? 255 : 0;
            res[8 * (2 - ch) +: 8] = 8'(mag);
        end
        return res;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_expected(int nout, bit ten, logic [7:0] th);
        for (int idx = 0; idx < nout; idx++) begin
            exp_t e;
            e.pix = model_pix(idx / COLS, idx % COLS, ten, th);
            e.sof = (idx == 0);
            e.eof = (idx == NPIX - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output got pix=%h sof=%b eof=%b", out_pix, out_sof, out_eof);
            end else begin
                e = exp_q.pop_front();
                if ({out_pix, out_sof, out_eof} !== {e.pix, e.sof, e.eof}) begin
                    n_fail++;
                    $display("FAIL out[%0d] got pix=%h sof=%b eof=%b want pix=%h sof=%b eof=%b",
                             cap_n, out_pix, out_sof, out_eof, e.pix, e.sof, e.eof);
                end
            end
            if (cap_n < NPIX) cap[cap_n] = out_pix;
            cap_n++;
        end
    end

    task automatic send_pix(logic [23:0] p, bit sof);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_pix   = p;
        in_sof   = sof;
        @(negedge CLK);
        while (!in_ready && waitc < 200) begin
            waitc++;
            @(negedge CLK);
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (rand_mode && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("busy_after_eof", busy, 0);
        check("out_count", cap_n, NPIX);
    endtask

    task automatic run_frame(bit ten, logic [7:0] th);
        thresh_en = ten;
        thresh    = th;
        cap_n     = 0;
        push_expected(NPIX, ten, th);
        for (int i = 0; i < NPIX; i++) begin
            send_pix(img[i / COLS][i % COLS], i == 0);
            if (i == 0) check("busy_in_frame", busy, 1);
        end
        wait_done();
    endtask

    task automatic set_img(int mode);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (mode)
                    0: img[r][c] = 24'h808080;
                    1: img[r][c] = (c < 4) ? 24'h000000 : 24'hFFFFFF;
                    2: img[r][c] = {3{8'(c * 16)}};
                    3: img[r][c] = {((c < 4) ? 8'h00 : 8'hFF), 16'h8080};
                    default: img[r][c] = 24'($urandom());
                endcase
    endtask

    task automatic compare_gold(string name);
        int mism;
        mism = 0;
        for (int i = 0; i < NPIX; i++) if (cap[i] !== gold[i]) mism++;
        check(name, mism, 0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cap_n     = 0;
        rand_mode = 1'b0;
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_pix    = '0;
        thresh_en = 1'b0;
        thresh    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_flags", {out_valid, out_sof, out_eof, busy}, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_in_ready", in_ready, 1);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        send_pix(24'h123456, 1'b0);
        send_pix(24'h654321, 1'b0);
        check("idle_drop_busy", busy, 0);

        set_img(0);
        check("model_flat", model_pix(2, 3, 0, 8'h00), 24'h000000);
        run_frame(1'b0, 8'h00);
        check("flat_first", cap[0], 24'h000000);
        check("flat_mid", cap[2 * COLS + 3], 24'h000000);

        set_img(1);
        check("model_step_r1c3", model_pix(1, 3, 0, 8'h00), 24'hFFFFFF);
        check("model_step_r2c2", model_pix(2, 2, 0, 8'h00), 24'h000000);
        run_frame(1'b0, 8'h00);
        check("step_r1c3", cap[1 * COLS + 3], 24'hFFFFFF);
        check("step_r4c4", cap[4 * COLS + 4], 24'hFFFFFF);
        check("step_r1c2", cap[1 * COLS + 2], 24'h000000);
        check("step_r1c5", cap[1 * COLS + 5], 24'h000000);
        check("step_r0c3_border", cap[0 * COLS + 3], 24'h000000);
        check("step_r5c4_border", cap[5 * COLS + 4], 24'h000000);

        // A 16-per-column ramp has a gradient magnitude of exactly 0x80 everywhere inside.
        set_img(2);
        check("model_ramp_mag", model_pix(2, 2, 0, 8'h00), 24'h808080);
        check("model_ramp_th81", model_pix(2, 2, 1, 8'h81), 24'h000000);
        run_frame(1'b1, 8'h40);
        check("ramp_th40_r2c2", cap[2 * COLS + 2], 24'hFFFFFF);
        check("ramp_th40_c0_border", cap[2 * COLS + 0], 24'h000000);
        run_frame(1'b1, 8'h80);
        check("ramp_th80_r3c5", cap[3 * COLS + 5], 24'hFFFFFF);
        run_frame(1'b1, 8'h81);
        check("ramp_th81_r3c5", cap[3 * COLS + 5], 24'h000000);

        set_img(3);
        run_frame(1'b0, 8'h00);
        check("rstep_r2c3", cap[2 * COLS + 3], 24'hFF0000);
        check("rstep_r2c4", cap[2 * COLS + 4], 24'hFF0000);
        check("rstep_r2c5", cap[2 * COLS + 5], 24'h000000);

        set_img(4);
        run_frame(1'b0, 8'h00);
        for (int i = 0; i < NPIX; i++) gold[i] = cap[i];
        rand_mode = 1'b1;
        run_frame(1'b0, 8'h00);
        rand_mode = 1'b0;
        compare_gold("stalled_vs_unstalled");

        // Abandoned frame: 30 pixels give 21 outputs with no eof, then a fresh sof.
        repeat (2) @(posedge CLK);
        #1;
        thresh_en = 1'b0;
        push_expected(30 - (COLS + 1), 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) send_pix(img[i / COLS][i % COLS], i == 0);
        repeat (2) @(posedge CLK);
        #1;
        check("abort_drained", exp_q.size(), 0);
        run_frame(1'b0, 8'h00);
        compare_gold("after_abort_vs_gold");

        push_expected(NPIX, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) send_pix(img[i / COLS][i % COLS], i == 0);
        RST = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        run_frame(1'b0, 8'h00);
        compare_gold("after_reset_vs_gold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
